// File: rtl/palette_lut_if.sv
`default_nettype none
// ============================================================================
//  Module      : palette_lut_if
//  Description : Pixel stream and host-side palette control bundle for
//                palette_lut.
//                master = index generator / host side (drives *_in)
//                slave  = palette_lut (drives *_out)
//  Signals     : idx_in, valid_in, bright_in        pixel request
//                color_out, valid_out, transp_out   scaled pixel result
//                wr_en_in, wr_addr_in, wr_data_in   shadow bank write
//                swap_in, frame_start_in            bank swap control
//                swap_pending_out, active_bank_out,
//                busy_out                           swap status
//  Revision    : 1.0 - initial release
// ============================================================================
interface palette_lut_if #(
    parameter int IDX_W   = 4,
    parameter int COLOR_W = 24
);
    logic [IDX_W-1:0]   idx_in;
    logic               valid_in;
    logic [7:0]         bright_in;
    logic [COLOR_W-1:0] color_out;
    logic               valid_out;
    logic               transp_out;
    logic               wr_en_in;
    logic [IDX_W-1:0]   wr_addr_in;
    logic [COLOR_W-1:0] wr_data_in;
    logic               swap_in;
    logic               frame_start_in;
    logic               swap_pending_out;
    logic               active_bank_out;
    logic               busy_out;

    modport master (
        output idx_in, valid_in, bright_in,
        output wr_en_in, wr_addr_in, wr_data_in,
        output swap_in, frame_start_in,
        input  color_out, valid_out, transp_out,
        input  swap_pending_out, active_bank_out, busy_out
    );

    modport slave (
        input  idx_in, valid_in, bright_in,
        input  wr_en_in, wr_addr_in, wr_data_in,
        input  swap_in, frame_start_in,
        output color_out, valid_out, transp_out,
        output swap_pending_out, active_bank_out, busy_out
    );
endinterface
`default_nettype wire

// File: rtl/palette_lut.sv
`default_nettype none
// ============================================================================
//  Module      : palette_lut
//  Description : Double-buffered programmable colour palette. Pixel indices
//                are looked up in the active bank and scaled by a per-pixel
//                brightness over a two-stage pipeline. Host writes go to the
//                shadow bank; a requested swap happens at the next frame
//                start and is followed by a copy-back of the new active bank
//                into the shadow so both stay coherent.
//  Ports       : clk_in  - system clock
//                rst_in  - synchronous active-high reset
//                bus     - palette_lut_if.slave (pixel, write, swap signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module palette_lut #(
    parameter int IDX_W      = 4,
    parameter int COLOR_W    = 24,
    parameter int TRANSP_IDX = 0
) (
    input  wire logic         clk_in,
    input  wire logic         rst_in,
    palette_lut_if.slave      bus
);
    localparam int c_DEPTH = 2 ** IDX_W;
    localparam int c_CW    = COLOR_W / 3;
    localparam int c_PW    = c_CW + 9;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_COPY = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Default palette, channels rescaled to c_CW bits. Placing the 8-bit
    // channel above c_CW zeros and taking the top c_CW bits truncates
    // when c_CW < 8 and zero-extends on the LSB side when c_CW > 8.
    // ------------------------------------------------------------------
    function automatic logic [COLOR_W-1:0] f_default(input int idx);
        logic [23:0]        rgb;
        logic [c_CW+7:0]    wide;
        logic [COLOR_W-1:0] res;
        res = '0;
        case (idx)
            0:       rgb = 24'h000000;
            1:       rgb = 24'h9d9d9d;
            2:       rgb = 24'hffffff;
            3:       rgb = 24'hbe2633;
            4:       rgb = 24'he06f8b;
            5:       rgb = 24'h493c2b;
            6:       rgb = 24'ha46422;
            7:       rgb = 24'heb8931;
            8:       rgb = 24'hf7e26b;
            9:       rgb = 24'h2f484e;
            10:      rgb = 24'h44891a;
            11:      rgb = 24'ha3ce27;
            12:      rgb = 24'h1b2632;
            13:      rgb = 24'h005784;
            14:      rgb = 24'h31a2f2;
            15:      rgb = 24'hb2dcef;
            default: rgb = 24'h000000;
        endcase
        for (int c = 0; c < 3; c++) begin
            wide = {rgb[23-8*c -: 8], {c_CW{1'b0}}};
            res[COLOR_W-1-c_CW*c -: c_CW] = wide[c_CW+7 -: c_CW];
        end
        return res;
    endfunction

    // ch * (bright + 1) >> 8 per channel; bright = 255 is identity.
    function automatic logic [COLOR_W-1:0] f_scale(input logic [COLOR_W-1:0] col,
                                                   input logic [7:0]         bright);
        logic [c_PW-1:0]    w_ch;
        logic [c_PW-1:0]    w_k;
        logic [c_PW-1:0]    w_prod;
        logic [COLOR_W-1:0] res;
        res = '0;
        w_k = c_PW'({1'b0, bright} + 9'd1);
        for (int c = 0; c < 3; c++) begin
            w_ch   = c_PW'(col[COLOR_W-1-c_CW*c -: c_CW]);
            w_prod = w_ch * w_k;
            res[COLOR_W-1-c_CW*c -: c_CW] = w_prod[c_CW+7:8];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [COLOR_W-1:0] r_bank0 [0:c_DEPTH-1];
    logic [COLOR_W-1:0] r_bank1 [0:c_DEPTH-1];

    // ------------------------------------------------------------------
    // Swap FSM registers and next-state signals
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nx;
    logic [IDX_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   w_cnt_nx;
    logic               r_active;
    logic               w_active_nx;
    logic               r_pending;
    logic               w_pending_nx;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_active  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_active  <= w_active_nx;
            r_pending <= w_pending_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_active_nx  = r_active;
        w_pending_nx = r_pending;
        case (r_state)
            S_IDLE: begin
                // Uses the registered pending flag, so a swap_in arriving
                // together with frame_start only arms the next frame.
                if (bus.frame_start_in && r_pending) begin
                    w_active_nx  = ~r_active;
                    w_pending_nx = 1'b0;
                    w_cnt_nx     = '0;
                    w_state_nx   = S_COPY;
                end
            end
            S_COPY: begin
                w_cnt_nx = r_cnt + IDX_W'(1);
                if (r_cnt == IDX_W'(c_DEPTH - 1)) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (bus.swap_in) begin
            w_pending_nx = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Bank update: host writes into the shadow while idle, copy-back of
    // active into shadow while copying. The shadow is chosen from the
    // current (pre-swap) r_active, so a write on the swap edge lands in
    // the bank that becomes active.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_bank0[i] <= f_default(i);
                r_bank1[i] <= f_default(i);
            end
        end else if (r_state == S_COPY) begin
            if (r_active) begin
                r_bank0[r_cnt] <= r_bank1[r_cnt];
            end else begin
                r_bank1[r_cnt] <= r_bank0[r_cnt];
            end
        end else if (bus.wr_en_in) begin
            if (r_active) begin
                r_bank0[bus.wr_addr_in] <= bus.wr_data_in;
            end else begin
                r_bank1[bus.wr_addr_in] <= bus.wr_data_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline
    // ------------------------------------------------------------------
    logic [COLOR_W-1:0] w_rd_color;
    logic [COLOR_W-1:0] r_s1_color;
    logic [7:0]         r_s1_bright;
    logic               r_s1_valid;
    logic               r_s1_transp;
    logic [COLOR_W-1:0] r_s2_color;
    logic               r_s2_valid;
    logic               r_s2_transp;

    assign w_rd_color = r_active ? r_bank1[bus.idx_in] : r_bank0[bus.idx_in];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_s1_color  <= '0;
            r_s1_bright <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_transp <= 1'b0;
            r_s2_color  <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_transp <= 1'b0;
        end else begin
            r_s1_color  <= w_rd_color;
            r_s1_bright <= bus.bright_in;
            r_s1_valid  <= bus.valid_in;
            r_s1_transp <= (bus.idx_in == IDX_W'(TRANSP_IDX));
            r_s2_color  <= f_scale(r_s1_color, r_s1_bright);
            r_s2_valid  <= r_s1_valid;
            r_s2_transp <= r_s1_transp;
        end
    end

    assign bus.color_out        = r_s2_color;
    assign bus.valid_out        = r_s2_valid;
    assign bus.transp_out       = r_s2_transp;
    assign bus.swap_pending_out = r_pending;
    assign bus.active_bank_out  = r_active;
    assign bus.busy_out         = (r_state == S_COPY);

endmodule
`default_nettype wire

// File: tb/tb_palette_lut.sv
`default_nettype none
// ============================================================================
//  Module      : tb_palette_lut
//  Description : Directed self-checking bench for palette_lut. Inputs are
//                driven and outputs sampled on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_palette_lut;
    localparam int c_IDX_W   = 4;
    localparam int c_COLOR_W = 24;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    palette_lut_if #(.IDX_W(c_IDX_W), .COLOR_W(c_COLOR_W)) bus ();

    palette_lut #(
        .IDX_W      (c_IDX_W),
        .COLOR_W    (c_COLOR_W),
        .TRANSP_IDX (0)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Issue one pixel and check the result two edges later.
    task automatic read_pix(input string tag, input logic [3:0] idx, input logic [7:0] br,
                            input logic [23:0] exp_col, input logic exp_tr);
        bus.idx_in    = idx;
        bus.bright_in = br;
        bus.valid_in  = 1'b1;
        step();
        bus.valid_in  = 1'b0;
        step();
        check({tag, "_color"}, 32'(bus.color_out), 32'(exp_col));
        check({tag, "_valid"}, 32'(bus.valid_out), 32'd1);
        check({tag, "_transp"}, 32'(bus.transp_out), 32'(exp_tr));
    endtask

    task automatic write_shadow(input logic [3:0] addr, input logic [23:0] data);
        bus.wr_en_in   = 1'b1;
        bus.wr_addr_in = addr;
        bus.wr_data_in = data;
        step();
        bus.wr_en_in   = 1'b0;
    endtask

    task automatic do_swap_and_wait(input string tag, input logic exp_bank);
        int n;
        bus.swap_in = 1'b1;
        step();
        bus.swap_in = 1'b0;
        check({tag, "_pending"}, 32'(bus.swap_pending_out), 32'd1);
        bus.frame_start_in = 1'b1;
        step();
        bus.frame_start_in = 1'b0;
        check({tag, "_bank"}, 32'(bus.active_bank_out), 32'(exp_bank));
        n = 0;
        while (bus.busy_out && n < 40) begin
            n++;
            step();
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'd16);
    endtask

    initial begin
        int n;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.idx_in = '0;  bus.valid_in = 1'b0;  bus.bright_in = '0;
        bus.wr_en_in = 1'b0;  bus.wr_addr_in = '0;  bus.wr_data_in = '0;
        bus.swap_in = 1'b0;  bus.frame_start_in = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_color",   32'(bus.color_out),        32'd0);
        check("rst_valid",   32'(bus.valid_out),        32'd0);
        check("rst_transp",  32'(bus.transp_out),       32'd0);
        check("rst_pending", 32'(bus.swap_pending_out), 32'd0);
        check("rst_bank",    32'(bus.active_bank_out),  32'd0);
        check("rst_busy",    32'(bus.busy_out),         32'd0);
        rst = 1'b0;
        step();

        // Default read and transparency
        read_pix("def3", 4'd3, 8'd255, 24'hbe2633, 1'b0);
        read_pix("def0", 4'd0, 8'd255, 24'h000000, 1'b1);
        // Brightness: ff*128>>8 = 7f ; be,26,33 * 128 >> 8 = 5f,13,19
        read_pix("br127", 4'd2, 8'd127, 24'h7f7f7f, 1'b0);
        read_pix("br0",   4'd2, 8'd0,   24'h000000, 1'b0);
        read_pix("br127c", 4'd3, 8'd127, 24'h5f1319, 1'b0);
        step();
        check("idle_valid", 32'(bus.valid_out), 32'd0);

        // Double buffering
        write_shadow(4'd5, 24'h123456);
        read_pix("shadow_hidden", 4'd5, 8'd255, 24'h493c2b, 1'b0);
        bus.swap_in = 1'b1;
        step();
        bus.swap_in = 1'b0;
        check("sw1_pending", 32'(bus.swap_pending_out), 32'd1);
        check("sw1_bank_pre", 32'(bus.active_bank_out), 32'd0);
        bus.frame_start_in = 1'b1;
        step();
        bus.frame_start_in = 1'b0;
        check("sw1_bank", 32'(bus.active_bank_out), 32'd1);
        check("sw1_pending_clr", 32'(bus.swap_pending_out), 32'd0);
        // Write during copy-back must be dropped
        bus.wr_en_in   = 1'b1;
        bus.wr_addr_in = 4'd7;
        bus.wr_data_in = 24'habcdef;
        n = 0;
        while (bus.busy_out && n < 40) begin
            n++;
            step();
            bus.wr_en_in = 1'b0;
        end
        bus.wr_en_in = 1'b0;
        check("sw1_busy_cycles", 32'(n), 32'd16);
        read_pix("sw1_rd5", 4'd5, 8'd255, 24'h123456, 1'b0);

        // Second swap: copied shadow must hold 123456, dropped write absent
        do_swap_and_wait("sw2", 1'b0);
        read_pix("sw2_rd5", 4'd5, 8'd255, 24'h123456, 1'b0);
        read_pix("sw2_rd7", 4'd7, 8'd255, 24'heb8931, 1'b0);

        // swap_in and frame_start_in together with pending clear: no swap
        bus.swap_in = 1'b1;
        bus.frame_start_in = 1'b1;
        step();
        bus.swap_in = 1'b0;
        bus.frame_start_in = 1'b0;
        check("sim_bank", 32'(bus.active_bank_out), 32'd0);
        check("sim_pending", 32'(bus.swap_pending_out), 32'd1);
        check("sim_busy", 32'(bus.busy_out), 32'd0);
        // Next frame start swaps; write on the same edge becomes visible
        bus.frame_start_in = 1'b1;
        bus.wr_en_in   = 1'b1;
        bus.wr_addr_in = 4'd9;
        bus.wr_data_in = 24'h0a0b0c;
        step();
        bus.frame_start_in = 1'b0;
        bus.wr_en_in = 1'b0;
        check("sim_swap_bank", 32'(bus.active_bank_out), 32'd1);
        check("sim_swap_busy", 32'(bus.busy_out), 32'd1);
        read_pix("sim_rd9", 4'd9, 8'd255, 24'h0a0b0c, 1'b0);

        // Mid-copy reset with a valid pixel in flight
        check("mid_busy_pre", 32'(bus.busy_out), 32'd1);
        bus.idx_in = 4'd9;
        bus.bright_in = 8'd255;
        bus.valid_in = 1'b1;
        step();
        bus.valid_in = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_busy", 32'(bus.busy_out), 32'd0);
        check("mid_bank", 32'(bus.active_bank_out), 32'd0);
        check("mid_valid0", 32'(bus.valid_out), 32'd0);
        check("mid_pending", 32'(bus.swap_pending_out), 32'd0);
        step();
        check("mid_valid1", 32'(bus.valid_out), 32'd0);
        read_pix("mid_rd5", 4'd5, 8'd255, 24'h493c2b, 1'b0);
        read_pix("mid_rd9", 4'd9, 8'd255, 24'h2f484e, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/palette_lut.md
# palette_lut

Programmable, double-buffered colour palette that replaces the fixed 16-entry lookup in the pixel path. It maps a pixel index to a `COLOR_W`-bit RGB colour through a two-stage pipeline, and applies a per-pixel brightness scale. The CPU/host side writes into a shadow bank. A requested bank swap takes effect only at a frame boundary, and the new palette is then copied back so the shadow stays coherent. It sits between the sprite/tile index generator and the HDMI/VGA output formatter.

## Interface

**Parameters**
- `IDX_W`, default 4: index width. `DEPTH = 2**IDX_W` entries per bank.
- `COLOR_W`, default 24: colour width. Must be a multiple of 3. `CW = COLOR_W/3` bits per channel, ordered R (MSB), G, B.
- `TRANSP_IDX`, default 0: index flagged as transparent.

**Ports** (clock and reset first)
- `clk_in`  in  1  system clock; single clock domain.
- `rst_in`  in  1  reset, synchronous and active-high.
- `idx_in`  in  `IDX_W`  pixel index.
- `valid_in`  in  1  `idx_in` is valid this cycle.
- `bright_in`  in  8  brightness, sampled with `idx_in`.
- `color_out`  out  `COLOR_W`  scaled colour.
- `valid_out`  out  1  `color_out`/`transp_out` are valid.
- `transp_out`  out  1  index equalled `TRANSP_IDX`.
- `wr_en_in`  in  1  write strobe to the shadow bank.
- `wr_addr_in`  in  `IDX_W`  write address.
- `wr_data_in`  in  `COLOR_W`  write data.
- `swap_in`  in  1  request a bank swap at the next frame start (1-cycle pulse).
- `frame_start_in`  in  1  1-cycle pulse at frame boundary (vsync).
- `swap_pending_out`  out  1  swap requested, not yet performed.
- `active_bank_out`  out  1  bank currently used for reads.
- `busy_out`  out  1  copy-back in progress; writes are ignored.

## Operation

**Storage**
- Two register banks, each `DEPTH` x `COLOR_W`.
- Reads always use the active bank; writes always go to the shadow (`!active_bank_out`).

**Reset contents**
- Both banks load the default palette for entries 0..15: 000000, 9d9d9d, ffffff, be2633, e06f8b, 493c2b, a46422, eb8931, f7e26b, 2f484e, 44891a, a3ce27, 1b2632, 005784, 31a2f2, b2dcef.
- Each 8-bit channel is truncated to its top `CW` bits, or zero-extended on the LSB side if `CW` > 8.
- Entries 16 and above reset to 0.
- If `IDX_W` < 4, only entries `0..DEPTH-1` are loaded.

**Pipeline**
- Stage 1 registers `active[idx_in]`, `bright_in`, `valid_in`, and `idx_in == TRANSP_IDX`.
- Stage 2 computes each channel as `ch_out = (ch * (bright + 1)) >> 8`, with an intermediate width of `CW + 9` and the result truncated to `CW`.
- `bright` = 255 is identity. `bright` = 0 gives `ch >> 8`, which is 0 for `CW` ≤ 8.
- Transparent pixels still output their scaled colour.

**Writes**
- A write with `wr_en_in` set and `busy_out` low updates `shadow[wr_addr_in]` on the clock edge.
- A write with `busy_out` high is dropped silently.

**Swap FSM: states IDLE, COPY; plus flag `pending`**
- `swap_in` sets `pending` in any state.
- In IDLE, `frame_start_in` with `pending` set (sampled before this cycle's `swap_in`): toggle the active bank, clear `pending`, go to COPY with counter = 0.
- `frame_start_in` without `pending`: no effect.
- In COPY, each cycle copies `active[cnt]` to `shadow[cnt]` and increments `cnt`. After entry `DEPTH-1` is copied, return to IDLE. COPY lasts exactly `DEPTH` cycles with `busy_out` high.
- `frame_start_in` during COPY does not swap; `pending` is retained for the next `frame_start_in` in IDLE.
- A write accepted in the same cycle as a swap lands in the old shadow, which is the new active bank, so it is visible and is propagated by the copy.

## Timing

- Latency `valid_in` to `valid_out` is 2 cycles, fully pipelined at 1 pixel/cycle. `valid_out` is low when `valid_in` was low.
- All outputs are registered.
- Reset values: `color_out` = 0, `valid_out` = 0, `transp_out` = 0, `swap_pending_out` = 0, `active_bank_out` = 0, `busy_out` = 0; FSM is in IDLE.
- A swap performed on edge N takes effect for `idx_in` sampled on edge N+1. Pixels already in the pipeline complete with the old bank.
- A written entry is readable in the shadow the cycle after the write edge; it is visible on reads only after a swap.
- `busy_out` rises the cycle after the swap edge and falls after `DEPTH` cycles.
- Reset mid-operation aborts COPY, clears the pipeline, clears `pending`, selects bank 0, and reloads the defaults into both banks.

## Test plan

- **Default read:** after reset, `idx_in` = 3, `bright_in` = 255, `valid_in` = 1 → two cycles later `color_out` = be2633, `valid_out` = 1, `transp_out` = 0. With `idx_in` = 0 → `transp_out` = 1.
- **Brightness scaling:** `idx_in` = 2, `bright_in` = 127 → `color_out` = 7f7f7f. With `bright_in` = 0 → 000000.
- **Double buffering:** write `shadow[5]` = 123456, then read index 5 → 493c2b. Pulse `swap_in`, then `frame_start_in` → `active_bank_out` = 1, and the next read of index 5 returns 123456.
- **Copy-back:** after the swap, `busy_out` = 1 for exactly 16 cycles. A write during that window is dropped. After copy-back, `shadow[5]` reads back 123456 after a second swap.
- **Simultaneous events:** `swap_in` and `frame_start_in` in the same cycle with `pending` = 0 → no swap and `swap_pending_out` = 1; the next `frame_start_in` swaps. A write on the swap cycle is visible on reads immediately after.
- **Mid-operation reset:** `rst_in` during COPY → next cycle `busy_out` = 0, `active_bank_out` = 0, index 5 reads 493c2b, and `valid_out` = 0 for two cycles.
